// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the vector data memory.
package dmem_pkg;

    localparam int unsigned DefWidth = 64;
    localparam int unsigned DefDepth = 64;
    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefRdLat = 2;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StBusy,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Element storage: one masked LANES-wide write port and one LANES-wide registered read port.
module dmem_array #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LANES = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = LANES * WIDTH
) (
    input  logic             clk,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0]    waddr,
    input  logic [LW-1:0]    wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [LW-1:0]    rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Callers keep addr+LANES within DEPTH, so the lane offset never wraps in practice.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[waddr + AW'(i)] <= wdata[i*WIDTH +: WIDTH];
            end
        end
        if (re) begin
            for (int i = 0; i < LANES; i++) begin
                rdata[i*WIDTH +: WIDTH] <= mem[raddr + AW'(i)];
            end
        end
    end

endmodule

// File: rtl/dmem_vector.sv
// Vector data memory: zero-fill sweep after reset, then one outstanding masked read/write
// request at a time with a valid/ready response handshake.
module dmem_vector
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned RD_LAT = DefRdLat,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = LANES * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LW-1:0]    req_wdata,
    input  logic [LANES-1:0] req_wmask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [LW-1:0]    rsp_rdata,
    output logic             rsp_err
);

    localparam int unsigned CntMax   = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [AW:0] LanesExt = LANES[AW:0];
    localparam logic [AW:0] DepthExt = DEPTH[AW:0];
    localparam logic [AW-1:0] LanesA = LANES[AW-1:0];
    localparam logic [AW-1:0] LastRow = AW'(DEPTH - LANES);

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic          err_q, err_d;

    logic             req_oob;
    logic [LANES-1:0] arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [LW-1:0]    arr_wdata;
    logic             arr_re;
    logic [LW-1:0]    arr_rdata;

    // Widened by one bit so the last legal window (addr+LANES == DEPTH) does not overflow.
    assign req_oob = ({1'b0, req_addr} + LanesExt) > DepthExt;

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        err_d     = err_q;
        arr_we    = '0;
        arr_waddr = req_addr;
        arr_wdata = req_wdata;
        arr_re    = 1'b0;
        unique case (state_q)
            StInit: begin
                arr_we    = '1;
                arr_waddr = sweep_q;
                arr_wdata = '0;
                sweep_d   = sweep_q + LanesA;
                if (sweep_q == LastRow) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    is_wr_d = req_we;
                    err_d   = req_oob;
                    cnt_d   = '0;
                    if (req_we) begin
                        arr_we  = req_oob ? '0 : req_wmask;
                        state_d = StResp;
                    end else begin
                        arr_re  = !req_oob;
                        state_d = (RD_LAT == 1) ? StResp : StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == CntMax[2:0]) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            sweep_q <= '0;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && err_q;
    // The array read register holds until the next accepted read, so it is stable in RESP.
    assign rsp_rdata = (rsp_valid && !is_wr_q && !err_q) ? arr_rdata : '0;

    dmem_array #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LANES(LANES)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .re   (arr_re),
        .raddr(req_addr),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_dmem_vector.sv
// Directed scoreboard bench for dmem_vector at default parameters.
module tb_dmem_vector;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [5:0]   req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   req_wmask;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_rdata;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         err;
        logic [255:0] rdata;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [64];

    always #5 clk = ~clk;

    dmem_vector dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 64'd0;
    endtask

    task automatic release_and_check_init();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("init_req_ready", {255'd0, req_ready}, 256'd0);
            check("init_rsp_valid", {255'd0, rsp_valid}, 256'd0);
            @(posedge clk);
            #1;
        end
        check("ready_after_init", {255'd0, req_ready}, 256'd1);
    endtask

    function automatic exp_t predict(input logic we, input logic [5:0] addr,
                                     input logic [255:0] wd, input logic [3:0] m);
        exp_t e;
        e.err   = 1'b0;
        e.rdata = '0;
        e.lat   = we ? 1 : 2;
        if (int'(addr) + 4 > 64) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) model[int'(addr) + i] = wd[i*64 +: 64];
            end
        end else begin
            for (int i = 0; i < 4; i++) e.rdata[i*64 +: 64] = model[int'(addr) + i];
        end
        return e;
    endfunction

    // Drive one request, wait for its response, compare, then hold rsp_ready low for
    // 'hold' extra cycles before completing the handshake.
    task automatic issue(input logic we, input logic [5:0] addr, input logic [255:0] wd,
                         input logic [3:0] m, input int hold);
        exp_t got;
        int   n;
        int   lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = m;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {255'd0, req_ready}, 256'd1);
        sb.push_back(predict(we, addr, wd, m));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        n   = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            lat++;
            n++;
        end
        check("rsp_valid_rise", {255'd0, rsp_valid}, 256'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 256'd0, 256'd1);
        end else begin
            got = sb.pop_front();
            check("latency", 256'(lat), 256'(got.lat));
            check("rsp_err", {255'd0, rsp_err}, {255'd0, got.err});
            check("rsp_rdata", rsp_rdata, got.rdata);
            check("ready_in_resp", {255'd0, req_ready}, 256'd0);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check("hold_valid", {255'd0, rsp_valid}, 256'd1);
                check("hold_rdata", rsp_rdata, got.rdata);
                check("hold_err", {255'd0, rsp_err}, {255'd0, got.err});
                check("hold_ready", {255'd0, req_ready}, 256'd0);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_dropped", {255'd0, rsp_valid}, 256'd0);
        check("ready_after_hs", {255'd0, req_ready}, 256'd1);
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] l3, input logic [63:0] l2,
                                           input logic [63:0] l1, input logic [63:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {255'd0, req_ready}, 256'd0);
        check("rst_rsp_valid", {255'd0, rsp_valid}, 256'd0);
        check("rst_rsp_err", {255'd0, rsp_err}, 256'd0);
        check("rst_rsp_rdata", rsp_rdata, 256'd0);
        release_and_check_init();

        issue(1'b0, 6'd0, '0, 4'h0, 0);
        issue(1'b1, 6'd8, pack4(64'd4, 64'd3, 64'd2, 64'd1), 4'hf, 0);
        issue(1'b0, 6'd8, '0, 4'h0, 0);
        issue(1'b0, 6'd7, '0, 4'h0, 0);
        issue(1'b1, 6'd8, pack4(64'hAA, 64'hBB, 64'hCC, 64'hDD), 4'b0101, 0);
        issue(1'b0, 6'd8, '0, 4'h0, 0);
        issue(1'b1, 6'd8, pack4(64'h11, 64'h22, 64'h33, 64'h44), 4'b0000, 0);
        issue(1'b0, 6'd8, '0, 4'h0, 0);

        issue(1'b0, 6'd61, '0, 4'h0, 0);
        issue(1'b1, 6'd60, pack4(64'h63, 64'h62, 64'h61, 64'h60), 4'hf, 0);
        issue(1'b1, 6'd62, pack4(64'hE3, 64'hE2, 64'hE1, 64'hE0), 4'hf, 0);
        issue(1'b0, 6'd60, '0, 4'h0, 0);

        issue(1'b0, 6'd8, '0, 4'h0, 5);
        issue(1'b1, 6'd12, pack4(64'd9, 64'd9, 64'd9, 64'd9), 4'hf, 0);

        // Reset while a read of addr 8 sits in BUSY.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'd8;
        check("busy_accept_ready", {255'd0, req_ready}, 256'd1);
        sb.push_back(predict(1'b0, 6'd8, '0, 4'h0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_no_rsp", {255'd0, rsp_valid}, 256'd0);
        rst = 1'b1;
        sb.delete();
        clear_model();
        #1;
        check("midrst_rsp_valid", {255'd0, rsp_valid}, 256'd0);
        check("midrst_req_ready", {255'd0, req_ready}, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_held_valid", {255'd0, rsp_valid}, 256'd0);
        release_and_check_init();
        issue(1'b0, 6'd8, '0, 4'h0, 0);
        issue(1'b0, 6'd60, '0, 4'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
